enet_rx_addr_filter: RTL and testbench

Receive-side destination-address filter in the ENET RX path, clocked on rx_clk. It sits downstream of the RX normal register block and consumes its PALR/PAUR/IALR/IAUR/GALR/GAUR outputs. It captures the first 6 bytes of each incoming frame (the destination address), computes the CRC-32 hash of those bytes, and returns one accept/reject verdict per frame to the RX FIFO writer.

---
 rtl/enet_rx_addr_filter.sv | 234 +++++++++++++++++++++++
 tb/tb_enet_rx_addr_filter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enet_rx_addr_filter.sv
// Destination-address filter for the ENET receive path.
// Captures the 6-byte DA of each frame, hashes it with the Ethernet CRC-32,
// and issues one accept/reject verdict per frame to the RX FIFO writer.
//
// Handshake: rx_valid qualifies rx_data, rx_sof and rx_eof in the same cycle.
// There is no ready; the filter always accepts a valid byte. filt_done is a
// one-cycle strobe with no backpressure. The other filt_* outputs hold their
// value until the next strobe.
module enet_rx_addr_filter #(
  parameter bit HASH_EN = 1'b1
) (
  input  logic        rx_clk,
  input  logic        rst_n,
  input  logic        prom,
  input  logic        bc_rej,
  input  logic [31:0] palr,
  input  logic [15:0] paur,
  input  logic [31:0] ialr,
  input  logic [31:0] iaur,
  input  logic [31:0] galr,
  input  logic [31:0] gaur,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_sof,
  input  logic        rx_eof,
  output logic        filt_done,
  output logic        filt_accept,
  output logic [1:0]  filt_class,
  output logic        filt_runt,
  output logic [5:0]  filt_hash,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DA       = 2'd1,
    S_DECIDE   = 2'd2,
    S_WAIT_EOF = 2'd3
  } state_t;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  localparam logic [1:0] CLASS_UNI   = 2'd0;
  localparam logic [1:0] CLASS_MULTI = 2'd1;
  localparam logic [1:0] CLASS_BCAST = 2'd2;

  // Reflected CRC-32 update for one byte, LSB first, no final inversion.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in,
                                           input logic [7:0]  data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  cnt_q;
  logic [47:0] da_q;
  logic [31:0] crc_q;
  logic        runt_q;
  logic        ended_q;

  // Per-frame snapshot of the register-block configuration.
  logic        snap_prom;
  logic        snap_bc_rej;
  logic [47:0] snap_pa;
  logic [31:0] snap_ialr, snap_iaur, snap_galr, snap_gaur;

  // Decide-stage results, one cycle ahead of the output registers.
  logic        vld_q;
  logic        v_accept_q;
  logic [1:0]  v_class_q;
  logic        v_runt_q;
  logic [5:0]  v_hash_q;

  logic        v_accept_d;
  logic [1:0]  v_class_d;
  logic [5:0]  v_hash_d;

  logic        sof_acc;
  logic        da_byte;
  logic        last_da;
  state_t      sof_next;

  assign sof_acc  = rx_valid & rx_sof;
  assign da_byte  = rx_valid & ~rx_sof & (state_q == S_DA);
  assign last_da  = (cnt_q == 3'd5);
  // A start byte that is also the end byte is a 1-byte runt: go straight to decide.
  assign sof_next = rx_eof ? S_DECIDE : S_DA;

  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge rx_clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a new rx_sof always wins and restarts capture.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (sof_acc) state_d = sof_next;
      end
      S_DA: begin
        if (sof_acc)                            state_d = sof_next;
        else if (rx_valid && (last_da || rx_eof)) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (sof_acc)                              state_d = sof_next;
        else if (ended_q || (rx_valid && rx_eof)) state_d = S_IDLE;
        else                                      state_d = S_WAIT_EOF;
      end
      S_WAIT_EOF: begin
        if (sof_acc)                 state_d = sof_next;
        else if (rx_valid && rx_eof) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // DA/CRC capture and configuration snapshot.
  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      cnt_q       <= 3'd0;
      da_q        <= 48'd0;
      crc_q       <= CRC_INIT;
      runt_q      <= 1'b0;
      ended_q     <= 1'b0;
      snap_prom   <= 1'b0;
      snap_bc_rej <= 1'b0;
      snap_pa     <= 48'd0;
      snap_ialr   <= 32'd0;
      snap_iaur   <= 32'd0;
      snap_galr   <= 32'd0;
      snap_gaur   <= 32'd0;
    end else if (sof_acc) begin
      cnt_q       <= 3'd1;
      da_q        <= {40'd0, rx_data};
      crc_q       <= crc_byte(CRC_INIT, rx_data);
      runt_q      <= rx_eof;
      ended_q     <= rx_eof;
      snap_prom   <= prom;
      snap_bc_rej <= bc_rej;
      snap_pa     <= {palr, paur};
      snap_ialr   <= ialr;
      snap_iaur   <= iaur;
      snap_galr   <= galr;
      snap_gaur   <= gaur;
    end else if (da_byte) begin
      cnt_q   <= cnt_q + 3'd1;
      da_q    <= {da_q[39:0], rx_data};
      crc_q   <= crc_byte(crc_q, rx_data);
      // An end marker on byte 6 is a complete DA, anything earlier is a runt.
      runt_q  <= rx_eof & ~last_da;
      ended_q <= rx_eof;
    end
  end

  // Verdict logic, evaluated from latched DA/CRC/snapshot while in DECIDE.
  always_comb begin
    logic       is_bcast;
    logic       is_mcast;
    logic [5:0] hash;
    logic       ind_hit;
    logic       grp_hit;

    is_bcast = &da_q;
    is_mcast = da_q[40] & ~is_bcast;
    hash     = HASH_EN ? crc_q[31:26] : 6'd0;
    ind_hit  = HASH_EN & (hash[5] ? snap_iaur[hash[4:0]] : snap_ialr[hash[4:0]]);
    grp_hit  = HASH_EN & (hash[5] ? snap_gaur[hash[4:0]] : snap_galr[hash[4:0]]);

    v_accept_d = 1'b0;
    v_class_d  = CLASS_UNI;
    v_hash_d   = 6'd0;

    if (!runt_q) begin
      v_hash_d = hash;
      if (is_bcast)      v_class_d = CLASS_BCAST;
      else if (is_mcast) v_class_d = CLASS_MULTI;
      else               v_class_d = CLASS_UNI;

      if (snap_prom)     v_accept_d = 1'b1;
      else if (is_bcast) v_accept_d = ~snap_bc_rej;
      else if (is_mcast) v_accept_d = grp_hit;
      else               v_accept_d = (da_q == snap_pa) | ind_hit;
    end
  end

  // Decide stage: capture the verdict in the single DECIDE cycle.
  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      vld_q      <= 1'b0;
      v_accept_q <= 1'b0;
      v_class_q  <= 2'd0;
      v_runt_q   <= 1'b0;
      v_hash_q   <= 6'd0;
    end else begin
      vld_q <= (state_q == S_DECIDE);
      if (state_q == S_DECIDE) begin
        v_accept_q <= v_accept_d;
        v_class_q  <= v_class_d;
        v_runt_q   <= runt_q;
        v_hash_q   <= v_hash_d;
      end
    end
  end

  // Output registers: strobe for one cycle, hold fields until the next verdict.
  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      filt_done   <= 1'b0;
      filt_accept <= 1'b0;
      filt_class  <= 2'd0;
      filt_runt   <= 1'b0;
      filt_hash   <= 6'd0;
    end else begin
      filt_done <= vld_q;
      if (vld_q) begin
        filt_accept <= v_accept_q;
        filt_class  <= v_class_q;
        filt_runt   <= v_runt_q;
        filt_hash   <= v_hash_q;
      end
    end
  end

endmodule

// File: tb/tb_enet_rx_addr_filter.sv
// Self-checking bench for enet_rx_addr_filter.
// Verdicts are packed as {accept, class[1:0], runt, hash[5:0]}.
module tb_enet_rx_addr_filter;

  logic        rx_clk = 1'b0;
  logic        rst_n;
  logic        prom, bc_rej;
  logic [31:0] palr;
  logic [15:0] paur;
  logic [31:0] ialr, iaur, galr, gaur;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_sof, rx_eof;
  logic        filt_done, filt_accept, filt_runt;
  logic [1:0]  filt_class;
  logic [5:0]  filt_hash;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int b6_cyc;
  int done_cyc;

  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];

  enet_rx_addr_filter #(.HASH_EN(1'b1)) dut (
    .rx_clk(rx_clk), .rst_n(rst_n), .prom(prom), .bc_rej(bc_rej),
    .palr(palr), .paur(paur), .ialr(ialr), .iaur(iaur),
    .galr(galr), .gaur(gaur),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_sof(rx_sof), .rx_eof(rx_eof),
    .filt_done(filt_done), .filt_accept(filt_accept), .filt_class(filt_class),
    .filt_runt(filt_runt), .filt_hash(filt_hash), .dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  always #5 rx_clk = ~rx_clk;
  always @(posedge rx_clk) cyc <= cyc + 1;

  // Verdict monitor, sampled on the falling edge.
  always @(negedge rx_clk) begin
    if (filt_done === 1'b1) begin
      obs_q.push_back({filt_accept, filt_class, filt_runt, filt_hash});
      done_cyc = cyc;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: frame verdict straight from the filtering rules.
  function automatic logic [9:0] ref_verdict(input logic [47:0] da, input int len);
    logic [31:0] c;
    logic [5:0]  h;
    logic [1:0]  cls;
    logic        acc, ihit, ghit, fb;
    if (len < 6) return {1'b0, 2'd0, 1'b1, 6'd0};
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 48; k++) begin
      // wire byte k/8 sits at da[47-8*(k/8) -: 8]; bits go out LSB first
      fb = c[0] ^ da[40 - 8 * (k / 8) + (k % 8)];
      c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
    end
    h    = c[31:26];
    ihit = h[5] ? iaur[h[4:0]] : ialr[h[4:0]];
    ghit = h[5] ? gaur[h[4:0]] : galr[h[4:0]];
    if (da == 48'hFFFF_FFFF_FFFF) cls = 2'd2;
    else if (da[40])              cls = 2'd1;
    else                          cls = 2'd0;
    if (prom)           acc = 1'b1;
    else if (cls == 2)  acc = !bc_rej;
    else if (cls == 1)  acc = ghit;
    else                acc = (da == {palr, paur}) || ihit;
    return {acc, cls, 1'b0, h};
  endfunction

  // Driver: send one frame; mod_at flips palr right after that byte index.
  task automatic send_frame(input logic [47:0] da, input int len, input int gap,
                            input bit eof_last, input int mod_at);
    exp_q.push_back(ref_verdict(da, len));
    for (int b = 0; b < len; b++) begin
      rx_valid = 1'b1;
      rx_sof   = (b == 0);
      rx_eof   = eof_last && (b == len - 1);
      if (b < 6) rx_data = da[47 - 8 * b -: 8];
      else       rx_data = 8'($urandom);
      @(posedge rx_clk); #1;
      rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'($urandom);
      if (b == 5) b6_cyc = cyc;
      if (b == mod_at) palr = ~palr;
      if (b < len - 1) repeat (gap) begin @(posedge rx_clk); #1; end
    end
  endtask

  // Wait (bounded) until all expected verdicts could have appeared.
  task automatic drain();
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 60) begin
      @(posedge rx_clk); #1;
      n++;
    end
    repeat (4) @(posedge rx_clk);
    #1;
  endtask

  task automatic set_cfg_zero();
    prom = 0; bc_rej = 0; palr = 32'h00112233; paur = 16'h4455;
    ialr = 0; iaur = 0; galr = 0; gaur = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 0; rx_sof = 0; rx_eof = 0; rx_data = 0;
    set_cfg_zero();
    repeat (3) @(posedge rx_clk);
    #1;
    total++;
    if ({filt_done, filt_accept, filt_class, filt_runt, filt_hash, dbg_state} !== 13'd0) begin
      bad++;
      $display("FAIL reset outputs: got done=%b acc=%b cls=%0d runt=%b hash=%h st=%0d, want all 0",
               filt_done, filt_accept, filt_class, filt_runt, filt_hash, dbg_state);
    end
    rst_n = 1'b1;
    @(posedge rx_clk); #1;
  endtask

  task automatic test_unicast();
    set_cfg_zero();
    send_frame(48'h0011_2233_4455, 64, 0, 1, -1);
    drain();
    total++;
    if (done_cyc !== b6_cyc + 2) begin
      bad++;
      $display("FAIL unicast latency: done at cycle %0d, want %0d", done_cyc, b6_cyc + 2);
    end
    while (exp_q.size() > 0) begin
      logic [9:0] e, o;
      e = exp_q.pop_front(); total++;
      if (e[9] !== 1'b1 || obs_q.size() == 0) begin
        bad++; $display("FAIL unicast verdict: got none/bad model, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL unicast verdict: got %h want %h", o, e); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL unicast extra: %0d unexpected verdicts", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_broadcast();
    set_cfg_zero();
    send_frame(48'hFFFF_FFFF_FFFF, 64, 0, 1, -1);
    bc_rej = 1;
    send_frame(48'hFFFF_FFFF_FFFF, 64, 0, 1, -1);
    bc_rej = 0;
    drain();
    while (exp_q.size() > 0) begin
      logic [9:0] e, o;
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL bcast verdict: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL bcast verdict: got %h want %h", o, e); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL bcast extra: %0d unexpected verdicts", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_multicast();
    logic [9:0] m;
    set_cfg_zero();
    galr = '1; gaur = '1;
    send_frame(48'h0100_5E00_0001, 64, 0, 1, -1);
    galr = 0; gaur = 0;
    send_frame(48'h0100_5E00_0001, 64, 0, 1, -1);
    m = ref_verdict(48'h0100_5E00_0001, 64);
    if (m[5]) gaur[m[4:0]] = 1'b1;
    else      galr[m[4:0]] = 1'b1;
    send_frame(48'h0100_5E00_0001, 64, 0, 1, -1);
    drain();
    while (exp_q.size() > 0) begin
      logic [9:0] e, o;
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL mcast verdict: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL mcast verdict: got %h want %h", o, e); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL mcast extra: %0d unexpected verdicts", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_runt();
    set_cfg_zero();
    prom = 1;
    send_frame(48'h0011_2233_4455, 4, 0, 1, -1);
    send_frame(48'hFFFF_FFFF_FFFF, 1, 0, 1, -1);
    prom = 0;
    drain();
    total++;
    if (dbg_state !== 2'd0) begin
      bad++; $display("FAIL runt state: got %0d want 0 (idle)", dbg_state);
    end
    while (exp_q.size() > 0) begin
      logic [9:0] e, o;
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL runt verdict: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL runt verdict: got %h want %h", o, e); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL runt extra: %0d unexpected verdicts", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_snapshot_gaps();
    set_cfg_zero();
    send_frame(48'h0011_2233_4455, 30, 0, 1, 1);   // palr flipped after byte 2
    palr = 32'h00112233;
    send_frame(48'h0011_2233_4455, 12, 3, 1, -1);  // 3-cycle gaps between bytes
    send_frame(48'h0011_2233_4456, 12, 3, 1, -1);
    drain();
    while (exp_q.size() > 0) begin
      logic [9:0] e, o;
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL snapshot verdict: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL snapshot verdict: got %h want %h", o, e); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL snapshot extra: %0d unexpected verdicts", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    set_cfg_zero();
    galr = 32'hA5A5_0F0F; gaur = 32'h3C3C_F00F;
    send_frame(48'h0011_2233_4455, 10, 0, 0, -1);  // no eof: next sof in WAIT_EOF
    send_frame(48'h0100_5E7F_0002, 20, 0, 1, -1);
    send_frame(48'hFFFF_FFFF_FFFF, 6, 0, 0, -1);   // next sof lands in DECIDE
    send_frame(48'h0000_0000_0000, 1, 0, 1, -1);   // sof+eof during DECIDE
    send_frame(48'h0011_2233_4455, 6, 0, 1, -1);   // eof on byte 6
    send_frame(48'h0100_5E00_00FB, 9, 0, 1, -1);
    drain();
    while (exp_q.size() > 0) begin
      logic [9:0] e, o;
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL b2b verdict: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL b2b verdict: got %h want %h", o, e); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL b2b extra: %0d unexpected verdicts", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 60; f++) begin
      logic [47:0] da;
      int kind;
      prom   = ($urandom_range(0, 7) == 0);
      bc_rej = 1'($urandom);
      palr   = $urandom; paur = 16'($urandom);
      ialr   = $urandom; iaur = $urandom; galr = $urandom; gaur = $urandom;
      da     = {16'($urandom), 32'($urandom)};
      kind   = $urandom_range(0, 3);
      if (kind == 0)      da = {palr, paur};
      else if (kind == 1) da = 48'hFFFF_FFFF_FFFF;
      else if (kind == 2) da[40] = 1'b1;
      else                da[40] = 1'b0;
      send_frame(da, $urandom_range(1, 20), $urandom_range(0, 2), 1, -1);
    end
    drain();
    while (exp_q.size() > 0) begin
      logic [9:0] e, o;
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL random verdict: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL random verdict: got %h want %h", o, e); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL random extra: %0d unexpected verdicts", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    logic [47:0] da;
    set_cfg_zero();
    send_frame(48'hFFFF_FFFF_FFFF, 8, 0, 1, -1);   // leaves non-zero outputs
    drain();
    exp_q.delete(); obs_q.delete();
    da = 48'h0011_2233_4455;
    for (int b = 0; b < 3; b++) begin
      rx_valid = 1; rx_sof = (b == 0); rx_eof = 0; rx_data = da[47 - 8 * b -: 8];
      @(posedge rx_clk); #1;
    end
    rx_valid = 0; rx_sof = 0;
    rst_n = 0;
    @(posedge rx_clk); #1;
    total++;
    if ({filt_done, filt_accept, filt_class, filt_runt, filt_hash, dbg_state} !== 13'd0) begin
      bad++;
      $display("FAIL midreset outputs: got done=%b acc=%b cls=%0d runt=%b hash=%h st=%0d, want all 0",
               filt_done, filt_accept, filt_class, filt_runt, filt_hash, dbg_state);
    end
    rst_n = 1;
    repeat (10) @(posedge rx_clk);
    #1;
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL midreset verdict: got %0d verdicts, want 0", obs_q.size()); obs_q.delete();
    end
    send_frame(da, 20, 0, 1, -1);
    drain();
    while (exp_q.size() > 0) begin
      logic [9:0] e, o;
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL midreset next: got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL midreset next: got %h want %h", o, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_broadcast();
    test_multicast();
    test_runt();
    test_snapshot_gaps();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
